// File: rtl/data_unpack_gen_if.sv
// data_unpack_gen_if: word-in / symbol-out stream bundle for the unpacker
interface data_unpack_gen_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 7
);
  logic                         valid_in;
  logic                         ready_out;
  logic [IN_W-1:0]              data_in;
  logic                         sop_in;
  logic                         eop_in;
  logic                         valid_out;
  logic                         ready_in;
  logic [OUT_W-1:0]             data_out;
  logic                         sop_out;
  logic                         eop_out;
  logic [$clog2(OUT_W+1)-1:0]   bits_out;
  logic                         pkt_err;
  modport slave (
    input  valid_in, data_in, sop_in, eop_in, ready_in,
    output ready_out, valid_out, data_out, sop_out, eop_out, bits_out, pkt_err
  );
  modport master (
    output valid_in, data_in, sop_in, eop_in, ready_in,
    input  ready_out, valid_out, data_out, sop_out, eop_out, bits_out, pkt_err
  );
endinterface

// File: rtl/data_unpack_gen.sv
// data_unpack_gen: packetised IN_W-bit word to OUT_W-bit symbol unpacker, MSB first
module data_unpack_gen #(
  parameter int  IN_W  = 32,
  parameter int  OUT_W = 7,
  localparam int CW    = $clog2(IN_W + OUT_W)
) (
  input logic clk,
  input logic rst,
  data_unpack_gen_if.slave bus
);
  localparam int BW  = IN_W + OUT_W - 1;
  localparam int BOW = $clog2(OUT_W + 1);
  localparam logic [CW-1:0] IW = CW'(IN_W);
  localparam logic [CW-1:0] OW = CW'(OUT_W);
  typedef enum logic [1:0] {IDLE, PKT, FLUSH} state_t;
  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sop_q, sop_d;
  logic            err_q, err_d;
  logic            acc, xfer, last;
  logic [BW-1:0]   ext;
  assign bus.ready_out = (state_q != FLUSH) && (cnt_q < OW);
  assign bus.valid_out = (cnt_q >= OW) || (state_q == FLUSH && cnt_q != '0);
  assign last          = (state_q == FLUSH) && (cnt_q <= OW);
  assign bus.eop_out   = bus.valid_out && last;
  assign bus.sop_out   = bus.valid_out && sop_q;
  assign bus.data_out  = buf_q[BW-1 -: OUT_W];
  assign bus.bits_out  = !bus.valid_out ? '0 : (cnt_q >= OW) ? BOW'(OUT_W) : BOW'(cnt_q);
  assign bus.pkt_err   = err_q;
  assign acc           = bus.valid_in && bus.ready_out;
  assign xfer          = bus.valid_out && bus.ready_in;
  // incoming word left-aligned in the buffer; shifted right by cnt it lands just below the held bits
  assign ext           = BW'(bus.data_in) << (OUT_W - 1);
  // next state: word accept and symbol transfer are mutually exclusive, so one branch each
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    err_d   = 1'b0;
    if (acc) begin
      err_d = (state_q == IDLE) != bus.sop_in;
      if (bus.sop_in) begin
        buf_d   = ext;
        cnt_d   = IW;
        sop_d   = 1'b1;
        state_d = bus.eop_in ? FLUSH : PKT;
      end else if (state_q == PKT) begin
        buf_d   = buf_q | (ext >> cnt_q);
        cnt_d   = cnt_q + IW;
        state_d = bus.eop_in ? FLUSH : PKT;
      end
    end else if (xfer) begin
      buf_d   = buf_q << OUT_W;
      cnt_d   = cnt_q - ((cnt_q < OW) ? cnt_q : OW);
      sop_d   = 1'b0;
      state_d = last ? IDLE : state_q;
    end
  end
  // state, buffer and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      sop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      err_q   <= err_d;
    end
  end
endmodule
